// File: rtl/countdown_timer_if.sv
// Signal bundle between the countdown timer and its controller/display.
// Carries the button/strobes and BCD presets in, the six BCD digits and status out.
interface countdown_timer_if;
  // No valid/ready pair: load and clear are single-cycle strobes acted on in
  // any cycle they are high. start_btn is a raw level. All outputs are registered
  // or decoded from registers and are valid every cycle.
  logic       start_btn;
  logic       load;
  logic       clear;
  logic [3:0] set_min_10;
  logic [3:0] set_min_1;
  logic [3:0] set_sec_10;
  logic [3:0] set_sec_1;
  logic [3:0] min_10;
  logic [3:0] min_1;
  logic [3:0] sec_10;
  logic [3:0] sec_1;
  logic [3:0] milli_10;
  logic [3:0] milli_1;
  logic       running;
  logic       done;
  logic       alarm;
  logic [1:0] state_dbg;

  modport master (
    output start_btn, load, clear, set_min_10, set_min_1, set_sec_10, set_sec_1,
    input  min_10, min_1, sec_10, sec_1, milli_10, milli_1, running, done, alarm,
           state_dbg
  );

  modport slave (
    input  start_btn, load, clear, set_min_10, set_min_1, set_sec_10, set_sec_1,
    output min_10, min_1, sec_10, sec_1, milli_10, milli_1, running, done, alarm,
           state_dbg
  );
endinterface

// File: rtl/countdown_timer.sv
// BCD countdown timer: counts a loaded mm:ss preset down to 00:00.00 in
// centisecond steps, with debounced start/pause button and a one-cycle alarm.
module countdown_timer #(
  parameter int unsigned TICK_DIV = 1_000_000,
  parameter int unsigned DEBOUNCE = 2_500_000
) (
  input logic              clk,
  input logic              reset_n,
  countdown_timer_if.slave bus
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = $clog2(DEBOUNCE + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [TW-1:0] pre_cnt;
  logic [DW-1:0] db_cnt;
  logic          press;
  logic          tick;
  logic          alarm_q;
  logic          borrow;

  // Digit packing, MSB first: min_10, min_1, sec_10, sec_1, milli_10, milli_1.
  logic [23:0] digits;
  logic [23:0] digits_dec;
  logic [23:0] shadow;
  logic [23:0] preset;

  function automatic logic [3:0] clamp_digit(input logic [3:0] v, input logic [3:0] max);
    return (v > max) ? max : v;
  endfunction

  assign preset = {clamp_digit(bus.set_min_10, 4'd9), clamp_digit(bus.set_min_1, 4'd9),
                   clamp_digit(bus.set_sec_10, 4'd5), clamp_digit(bus.set_sec_1, 4'd9),
                   8'h00};

  // Counter saturates at DEBOUNCE, so a long hold yields only one event.
  assign press = bus.start_btn && (db_cnt == DW'(DEBOUNCE - 1));
  assign tick  = (state == ST_RUN) && (pre_cnt == TW'(TICK_DIV - 1));

  // One-centisecond BCD decrement; sec_10 (digit 3) wraps to 5, the rest to 9.
  always_comb begin
    digits_dec = digits;
    borrow     = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (borrow) begin
        if (digits[i*4 +: 4] == 4'd0) begin
          digits_dec[i*4 +: 4] = (i == 3) ? 4'd5 : 4'd9;
        end else begin
          digits_dec[i*4 +: 4] = digits[i*4 +: 4] - 4'd1;
          borrow               = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (bus.clear || bus.load) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (press && (digits != 24'h0)) state_nxt = ST_RUN;
        ST_RUN: begin
          if (press)                                state_nxt = ST_PAUSE;
          else if (tick && (digits_dec == 24'h0))   state_nxt = ST_DONE;
        end
        ST_PAUSE: if (press) state_nxt = ST_RUN;
        default:  state_nxt = state;
      endcase
    end
  end

  always_comb begin
    bus.running   = (state == ST_RUN);
    bus.done      = (state == ST_DONE);
    bus.alarm     = alarm_q;
    bus.state_dbg = state;
    bus.min_10    = digits[23:20];
    bus.min_1     = digits[19:16];
    bus.sec_10    = digits[15:12];
    bus.sec_1     = digits[11:8];
    bus.milli_10  = digits[7:4];
    bus.milli_1   = digits[3:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      digits  <= '0;
      shadow  <= '0;
      pre_cnt <= '0;
      db_cnt  <= '0;
      alarm_q <= 1'b0;
    end else begin
      alarm_q <= (state_nxt == ST_DONE) && (state != ST_DONE);

      if (!bus.start_btn)                 db_cnt <= '0;
      else if (db_cnt != DW'(DEBOUNCE))   db_cnt <= db_cnt + DW'(1);

      if (bus.clear) begin
        digits <= shadow;
      end else if (bus.load) begin
        digits <= preset;
        shadow <= preset;
      end else if (tick && !press) begin
        digits <= digits_dec;
      end

      // Restart the prescaler on every entry to RUN; it holds while paused.
      if ((state_nxt == ST_RUN) && (state != ST_RUN)) begin
        pre_cnt <= '0;
      end else if ((state == ST_RUN) && (state_nxt == ST_RUN)) begin
        pre_cnt <= tick ? '0 : pre_cnt + TW'(1);
      end
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer with a small divider and debounce,
// modelling the timer value as a plain centisecond count.
module tb_countdown_timer;
  localparam int TICK_DIV = 4;
  localparam int DEBOUNCE = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  logic [23:0] exp_q[$];
  logic [23:0] shown;

  countdown_timer_if bus ();

  countdown_timer #(.TICK_DIV(TICK_DIV), .DEBOUNCE(DEBOUNCE)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  assign shown = {bus.min_10, bus.min_1, bus.sec_10, bus.sec_1, bus.milli_10, bus.milli_1};

  // Reference model: value as total centiseconds.
  function automatic int clamp_cs(input int m10, input int m1, input int s10, input int s1);
    int a, b, c, d;
    a = (m10 > 9) ? 9 : m10;
    b = (m1 > 9) ? 9 : m1;
    c = (s10 > 5) ? 5 : s10;
    d = (s1 > 9) ? 9 : s1;
    return ((a * 10 + b) * 60 + c * 10 + d) * 100;
  endfunction

  function automatic logic [23:0] cs_digits(input int cs);
    int m, s, c;
    m = cs / 6000;
    s = (cs / 100) % 60;
    c = cs % 100;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_load(input int m10, input int m1, input int s10, input int s1);
    bus.set_min_10 = 4'(m10);
    bus.set_min_1  = 4'(m1);
    bus.set_sec_10 = 4'(s10);
    bus.set_sec_1  = 4'(s1);
    bus.load = 1'b1;
    step(1);
    bus.load = 1'b0;
  endtask

  task automatic drive_clear(input bit with_load);
    bus.clear = 1'b1;
    bus.load  = with_load;
    step(1);
    bus.clear = 1'b0;
    bus.load  = 1'b0;
  endtask

  task automatic press_btn;
    bus.start_btn = 1'b1;
    step(DEBOUNCE);
    bus.start_btn = 1'b0;
  endtask

  task automatic test_reset;
    total++;
    if (shown !== 24'h0 || bus.running !== 1'b0 || bus.done !== 1'b0 || bus.alarm !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: digits=%h run=%b done=%b alarm=%b, want 000000 0 0 0",
               shown, bus.running, bus.done, bus.alarm);
    end
  endtask

  task automatic test_reset_mid_run;
    drive_load(0, 0, 3, 0);
    press_btn();
    step(10);
    #2 reset_n = 1'b0;
    #1;
    total++;
    if (shown !== 24'h0 || bus.running !== 1'b0 || bus.done !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: digits=%h run=%b done=%b, want 000000 0 0",
               shown, bus.running, bus.done);
    end
    @(negedge clk);
    reset_n = 1'b1;
    drive_clear(1'b0);
    total++;
    if (shown !== 24'h0 || bus.running !== 1'b0) begin
      bad++;
      $display("FAIL reset_clear: digits=%h run=%b, want 000000 0", shown, bus.running);
    end
  endtask

  task automatic test_run_to_done;
    int alarms;
    drive_load(0, 0, 0, 1);
    press_btn();
    step(TICK_DIV - 1);
    total++;
    if (shown !== cs_digits(100) || bus.running !== 1'b1) begin
      bad++;
      $display("FAIL first_tick_early: digits=%h run=%b, want %h 1", shown, bus.running, cs_digits(100));
    end
    step(1);
    total++;
    if (shown !== cs_digits(99)) begin
      bad++;
      $display("FAIL first_tick: digits=%h, want %h", shown, cs_digits(99));
    end
    step(98 * TICK_DIV + TICK_DIV - 1);
    total++;
    if (shown !== cs_digits(1) || bus.done !== 1'b0) begin
      bad++;
      $display("FAIL before_done: digits=%h done=%b, want %h 0", shown, bus.done, cs_digits(1));
    end
    step(1);
    total++;
    if (shown !== 24'h0 || bus.done !== 1'b1 || bus.alarm !== 1'b1 || bus.running !== 1'b0) begin
      bad++;
      $display("FAIL done_entry: digits=%h done=%b alarm=%b run=%b, want 000000 1 1 0",
               shown, bus.done, bus.alarm, bus.running);
    end
    alarms = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (bus.alarm === 1'b1) alarms++;
    end
    total++;
    if (alarms != 0 || bus.done !== 1'b1) begin
      bad++;
      $display("FAIL alarm_pulse: extra_alarms=%0d done=%b, want 0 1", alarms, bus.done);
    end
    press_btn();
    step(2);
    total++;
    if (bus.done !== 1'b1 || shown !== 24'h0) begin
      bad++;
      $display("FAIL done_press: done=%b digits=%h, want 1 000000", bus.done, shown);
    end
    drive_clear(1'b0);
    total++;
    if (bus.done !== 1'b0 || shown !== cs_digits(100)) begin
      bad++;
      $display("FAIL done_clear: done=%b digits=%h, want 0 %h", bus.done, shown, cs_digits(100));
    end
  endtask

  task automatic test_borrow;
    drive_load(1, 0, 0, 0);
    press_btn();
    step(TICK_DIV);
    total++;
    if (shown !== cs_digits(60000 - 1)) begin
      bad++;
      $display("FAIL borrow_10min: digits=%h, want %h", shown, cs_digits(60000 - 1));
    end
    drive_load(0, 1, 0, 0);
    total++;
    if (bus.running !== 1'b0) begin
      bad++;
      $display("FAIL load_to_idle: run=%b, want 0", bus.running);
    end
    press_btn();
    step(TICK_DIV);
    total++;
    if (shown !== cs_digits(6000 - 1)) begin
      bad++;
      $display("FAIL borrow_1min: digits=%h, want %h", shown, cs_digits(6000 - 1));
    end
  endtask

  task automatic test_pause_resume;
    int  seen;
    bit  moved;
    drive_load(0, 0, 4, 6);
    press_btn();
    seen = 0;
    for (int i = 0; i < 400 && seen == 0; i++) begin
      if (shown === cs_digits(4530)) seen = 1;
      else step(1);
    end
    total++;
    if (seen == 0) begin
      bad++;
      $display("FAIL reach_45_30: digits=%h, want %h within budget", shown, cs_digits(4530));
    end
    // Time the press to land on the same edge as the next tick.
    step(1);
    press_btn();
    total++;
    if (bus.running !== 1'b0 || shown !== cs_digits(4530)) begin
      bad++;
      $display("FAIL pause: run=%b digits=%h, want 0 %h", bus.running, shown, cs_digits(4530));
    end
    moved = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step(1);
      if (shown !== cs_digits(4530)) moved = 1'b1;
    end
    total++;
    if (moved) begin
      bad++;
      $display("FAIL pause_frozen: digits=%h moved=%b, want %h 0", shown, moved, cs_digits(4530));
    end
    press_btn();
    step(TICK_DIV - 1);
    total++;
    if (bus.running !== 1'b1 || shown !== cs_digits(4530)) begin
      bad++;
      $display("FAIL resume_early: run=%b digits=%h, want 1 %h", bus.running, shown, cs_digits(4530));
    end
    step(1);
    total++;
    if (shown !== cs_digits(4529)) begin
      bad++;
      $display("FAIL resume_tick: digits=%h, want %h", shown, cs_digits(4529));
    end
  endtask

  task automatic test_debounce;
    int       changes;
    logic [1:0] prev;
    drive_load(0, 5, 0, 0);
    bus.start_btn = 1'b1;
    step(DEBOUNCE - 1);
    bus.start_btn = 1'b0;
    step(4);
    total++;
    if (bus.running !== 1'b0 || shown !== cs_digits(30000)) begin
      bad++;
      $display("FAIL short_press: run=%b digits=%h, want 0 %h", bus.running, shown, cs_digits(30000));
    end
    changes = 0;
    prev = {bus.running, bus.done};
    bus.start_btn = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step(1);
      if ({bus.running, bus.done} !== prev) changes++;
      prev = {bus.running, bus.done};
    end
    bus.start_btn = 1'b0;
    step(2);
    total++;
    if (changes != 1 || bus.running !== 1'b1) begin
      bad++;
      $display("FAIL long_hold: changes=%0d run=%b, want 1 1", changes, bus.running);
    end
    drive_load(0, 0, 0, 0);
    press_btn();
    step(2 * TICK_DIV);
    total++;
    if (bus.running !== 1'b0 || bus.done !== 1'b0 || shown !== 24'h0) begin
      bad++;
      $display("FAIL zero_press: run=%b done=%b digits=%h, want 0 0 000000",
               bus.running, bus.done, shown);
    end
  endtask

  task automatic test_clamp_priority;
    drive_load(15, 3, 7, 12);
    total++;
    if (shown !== 24'h935900) begin
      bad++;
      $display("FAIL clamp_fixed: digits=%h, want 935900", shown);
    end
    press_btn();
    step(TICK_DIV);
    bus.set_min_10 = 4'd0;
    bus.set_min_1  = 4'd1;
    bus.set_sec_10 = 4'd0;
    bus.set_sec_1  = 4'd2;
    drive_clear(1'b1);
    total++;
    if (shown !== 24'h935900 || bus.running !== 1'b0) begin
      bad++;
      $display("FAIL clear_over_load: digits=%h run=%b, want 935900 0", shown, bus.running);
    end
    drive_clear(1'b0);
    total++;
    if (shown !== 24'h935900) begin
      bad++;
      $display("FAIL shadow_kept: digits=%h, want 935900", shown);
    end
    for (int i = 0; i < 6; i++) begin
      int a, b, c, d;
      a = $urandom_range(0, 15);
      b = $urandom_range(0, 15);
      c = $urandom_range(0, 15);
      d = $urandom_range(0, 15);
      drive_load(a, b, c, d);
      total++;
      if (shown !== cs_digits(clamp_cs(a, b, c, d))) begin
        bad++;
        $display("FAIL clamp_rand: in=%0d,%0d,%0d,%0d digits=%h, want %h",
                 a, b, c, d, shown, cs_digits(clamp_cs(a, b, c, d)));
      end
    end
  endtask

  task automatic test_random_runs;
    for (int it = 0; it < 8; it++) begin
      int cs, k, m1, s10, s1;
      logic [23:0] exp;
      m1  = (it % 2 == 0) ? 0 : $urandom_range(0, 1);
      s10 = $urandom_range(0, 7);
      s1  = $urandom_range(0, 12);
      if (it == 0) begin
        s10 = 0;
        s1  = 0;
      end
      cs = clamp_cs(0, m1, s10, s1);
      drive_load(0, m1, s10, s1);
      total++;
      if (shown !== cs_digits(cs)) begin
        bad++;
        $display("FAIL rand_load: digits=%h, want %h", shown, cs_digits(cs));
      end
      k = (cs <= 100) ? cs : $urandom_range(1, 20);
      for (int j = 1; j <= k; j++) exp_q.push_back(cs_digits(cs - j));
      press_btn();
      while (exp_q.size() > 0) begin
        step(TICK_DIV);
        exp = exp_q.pop_front();
        total++;
        if (shown !== exp) begin
          bad++;
          $display("FAIL rand_tick: digits=%h, want %h", shown, exp);
        end
      end
      step(1);
      total++;
      if (bus.running !== (cs - k != 0) || bus.done !== (cs != 0 && cs - k == 0)) begin
        bad++;
        $display("FAIL rand_state: run=%b done=%b, want %b %b",
                 bus.running, bus.done, (cs - k != 0), (cs != 0 && cs - k == 0));
      end
    end
  endtask

  initial begin
    bus.start_btn  = 1'b0;
    bus.load       = 1'b0;
    bus.clear      = 1'b0;
    bus.set_min_10 = 4'd0;
    bus.set_min_1  = 4'd0;
    bus.set_sec_10 = 4'd0;
    bus.set_sec_1  = 4'd0;
    step(3);
    reset_n = 1'b1;
    step(1);
    test_reset();
    test_reset_mid_run();
    test_run_to_done();
    test_borrow();
    test_pause_resume();
    test_debounce();
    test_clamp_priority();
    test_random_runs();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
